// File: rtl/issue_queue_if.sv
// Decoder-to-issue-queue-to-EX bundle: enqueue handshake, control and issued lanes.
interface issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int PKT_W = 128
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]       in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] in_pkt_a;
  logic [PKT_W-1:0] in_pkt_b;
  logic [17:0]      in_info_a;
  logic [17:0]      in_info_b;
  logic             flush;
  logic             stall;
  logic             ex_valid_a;
  logic             ex_valid_b;
  logic [PKT_W-1:0] ex_pkt_a;
  logic [PKT_W-1:0] ex_pkt_b;
  logic [CW-1:0]    count;

  // Decoder / test driver side
  modport master (
    output in_valid, in_pkt_a, in_pkt_b, in_info_a, in_info_b, flush, stall,
    input  in_ready, ex_valid_a, ex_valid_b, ex_pkt_a, ex_pkt_b, count
  );

  // Issue queue side
  modport slave (
    input  in_valid, in_pkt_a, in_pkt_b, in_info_a, in_info_b, flush, stall,
    output in_ready, ex_valid_a, ex_valid_b, ex_pkt_a, ex_pkt_b, count
  );
endinterface

// File: rtl/issue_queue.sv
// Dual-issue circular dispatch buffer feeding the registered EX lanes A and B.
// Hazard info layout: {is_load, is_mem, rf_we, rf_waddr[4:0], rf_raddr1[4:0], rf_raddr2[4:0]}.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int PKT_W = 128
) (
  input logic         clk,
  input logic         rstn,
  issue_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PKT_W-1:0] r_pkt [DEPTH];
  logic [17:0]      r_info [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             r_exValidA;
  logic             r_exValidB;
  logic [PKT_W-1:0] r_exPktA;
  logic [PKT_W-1:0] r_exPktB;
  logic             r_exLoadWe;
  logic [4:0]       r_exWaddr;

  logic             w_inReady;
  logic             w_enq;
  logic [CW-1:0]    w_enqNum;
  logic [PW-1:0]    w_head1;
  logic [PW-1:0]    w_tail1;
  logic [17:0]      w_h0Info;
  logic [9:0]       w_h1Raddr;
  logic             w_h1We;
  logic [4:0]       w_h1Waddr;
  logic             w_h0Ok;
  logic             w_h1Ok;
  logic             w_raw;
  logic             w_waw;
  logic             w_pair;
  logic [CW-1:0]    w_deq;

  // A candidate waits when the load now in lane B writes a nonzero register it reads.
  function automatic logic loadUse(input logic loadWe, input logic [4:0] waddr,
                                   input logic [9:0] raddrs);
    return loadWe && (waddr != 5'd0) && ((waddr == raddrs[9:5]) || (waddr == raddrs[4:0]));
  endfunction

  assign w_head1 = r_head + PW'(1);
  assign w_tail1 = r_tail + PW'(1);
  assign w_inReady = (CW'(DEPTH) - r_count) >= CW'(2);
  assign w_enq = bus.in_valid[0] && w_inReady && !bus.flush;

  // Enqueue width and the head-pair issue decision with its hazard checks.
  always_comb begin
    w_enqNum  = '0;
    w_h0Info  = r_info[r_head];
    w_h1Raddr = r_info[w_head1][9:0];
    w_h1We    = r_info[w_head1][15];
    w_h1Waddr = r_info[w_head1][14:10];
    w_h0Ok    = 1'b0;
    w_h1Ok    = 1'b0;
    w_raw     = 1'b0;
    w_waw     = 1'b0;
    w_pair    = 1'b0;
    w_deq     = '0;
    if (w_enq) begin
      w_enqNum = bus.in_valid[1] ? CW'(2) : CW'(1);
    end
    w_h0Ok = (r_count >= CW'(1)) && !loadUse(r_exLoadWe, r_exWaddr, w_h0Info[9:0]);
    w_h1Ok = (r_count >= CW'(2)) && !loadUse(r_exLoadWe, r_exWaddr, w_h1Raddr);
    w_raw  = w_h0Info[15] && (w_h0Info[14:10] != 5'd0) &&
             ((w_h0Info[14:10] == w_h1Raddr[9:5]) || (w_h0Info[14:10] == w_h1Raddr[4:0]));
    w_waw  = w_h0Info[15] && w_h1We && (w_h0Info[14:10] != 5'd0) &&
             (w_h0Info[14:10] == w_h1Waddr);
    w_pair = w_h0Ok && !w_h0Info[16] && w_h1Ok && !w_raw && !w_waw;
    if (!bus.stall && !bus.flush && w_h0Ok) begin
      w_deq = w_pair ? CW'(2) : CW'(1);
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_deq);
      r_tail  <= r_tail + PW'(w_enqNum);
      r_count <= r_count + w_enqNum - w_deq;
    end
  end

  // Entry storage; in_ready guarantees both target slots are free.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pkt[r_tail]  <= bus.in_pkt_a;
      r_info[r_tail] <= bus.in_info_a;
      if (bus.in_valid[1]) begin
        r_pkt[w_tail1]  <= bus.in_pkt_b;
        r_info[w_tail1] <= bus.in_info_b;
      end
    end
  end

  // EX-stage lane registers and the lane-B load tracking used for load-use stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_exValidA <= 1'b0;
      r_exValidB <= 1'b0;
      r_exPktA   <= '0;
      r_exPktB   <= '0;
      r_exLoadWe <= 1'b0;
      r_exWaddr  <= '0;
    end else if (bus.flush) begin
      r_exValidA <= 1'b0;
      r_exValidB <= 1'b0;
      r_exLoadWe <= 1'b0;
      r_exWaddr  <= '0;
    end else if (!bus.stall) begin
      if (!w_h0Ok) begin
        r_exValidA <= 1'b0;
        r_exValidB <= 1'b0;
        r_exLoadWe <= 1'b0;
        r_exWaddr  <= '0;
      end else if (w_h0Info[16]) begin
        r_exValidA <= 1'b0;
        r_exValidB <= 1'b1;
        r_exPktB   <= r_pkt[r_head];
        r_exLoadWe <= w_h0Info[17] && w_h0Info[15];
        r_exWaddr  <= w_h0Info[14:10];
      end else begin
        r_exValidA <= 1'b1;
        r_exPktA   <= r_pkt[r_head];
        r_exValidB <= w_pair;
        if (w_pair) begin
          r_exPktB   <= r_pkt[w_head1];
          r_exLoadWe <= r_info[w_head1][17] && w_h1We;
          r_exWaddr  <= w_h1Waddr;
        end else begin
          r_exLoadWe <= 1'b0;
          r_exWaddr  <= '0;
        end
      end
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.ex_valid_a = r_exValidA;
  assign bus.ex_valid_b = r_exValidB;
  assign bus.ex_pkt_a   = r_exPktA;
  assign bus.ex_pkt_b   = r_exPktB;
  assign bus.count      = r_count;
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios then random traffic
// compared against a queue-based behavioural model.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int PKT_W = 128;

  typedef struct packed {
    logic       isLoad;
    logic       isMem;
    logic       we;
    logic [4:0] wa;
    logic [4:0] r1;
    logic [4:0] r2;
  } info_t;

  typedef struct {
    logic [PKT_W-1:0] pkt;
    info_t            info;
  } entry_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int total = 0;
  int bad = 0;

  entry_t           mq[$];
  bit               mVA, mVB;
  logic [PKT_W-1:0] mPA, mPB;
  info_t            mExB;

  issue_queue_if #(.DEPTH(DEPTH), .PKT_W(PKT_W)) iq();

  issue_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (iq)
  );

  always #5 clk = ~clk;

  function automatic info_t mk(bit ld, bit mem, bit we, int wa, int r1, int r2);
    info_t i;
    i.isLoad = ld; i.isMem = mem; i.we = we;
    i.wa = 5'(wa); i.r1 = 5'(r1); i.r2 = 5'(r2);
    return i;
  endfunction

  function automatic info_t rndInfo();
    info_t i;
    i.isMem  = ($urandom_range(0, 9) < 3);
    i.isLoad = i.isMem && ($urandom_range(0, 1) == 1);
    i.we     = i.isLoad || ($urandom_range(0, 1) == 1);
    i.wa     = 5'($urandom_range(0, 7));
    i.r1     = 5'($urandom_range(0, 7));
    i.r2     = 5'($urandom_range(0, 7));
    return i;
  endfunction

  function automatic logic [PKT_W-1:0] rndPkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit loadUseHit(info_t c);
    return mExB.isLoad && mExB.we && (mExB.wa != 0) && ((mExB.wa == c.r1) || (mExB.wa == c.r2));
  endfunction

  // Reference model: one clock edge worth of behaviour, from the pre-edge state.
  task automatic modelStep(input logic [1:0] v, input logic [PKT_W-1:0] pa, input logic [PKT_W-1:0] pb,
                           input info_t ia, input info_t ib, input bit fl, input bit st);
    bit ready;
    bit canPair;
    int nIssue;
    entry_t e;
    ready = (DEPTH - mq.size()) >= 2;
    nIssue = 0;
    if (fl) begin
      mq.delete();
      mVA = 0; mVB = 0; mExB = '0;
      return;
    end
    if (!st) begin
      if (mq.size() == 0 || loadUseHit(mq[0].info)) begin
        mVA = 0; mVB = 0; mExB = '0;
      end else if (mq[0].info.isMem) begin
        mVA = 0; mVB = 1; mPB = mq[0].pkt; mExB = mq[0].info; nIssue = 1;
      end else begin
        mVA = 1; mPA = mq[0].pkt; nIssue = 1;
        canPair = 0;
        if (mq.size() >= 2) begin
          canPair = !loadUseHit(mq[1].info)
            && !(mq[0].info.we && mq[0].info.wa != 0 &&
                 (mq[0].info.wa == mq[1].info.r1 || mq[0].info.wa == mq[1].info.r2))
            && !(mq[0].info.we && mq[1].info.we && mq[0].info.wa != 0 && mq[0].info.wa == mq[1].info.wa);
        end
        if (canPair) begin
          mVB = 1; mPB = mq[1].pkt; mExB = mq[1].info; nIssue = 2;
        end else begin
          mVB = 0; mExB = '0;
        end
      end
      repeat (nIssue) void'(mq.pop_front());
    end
    if (ready && v[0]) begin
      e.pkt = pa; e.info = ia; mq.push_back(e);
      if (v[1]) begin
        e.pkt = pb; e.info = ib; mq.push_back(e);
      end
    end
  endtask

  task automatic check(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".count"}, PKT_W'(iq.count), PKT_W'(mq.size()));
    check({tag, ".in_ready"}, PKT_W'(iq.in_ready), PKT_W'((DEPTH - mq.size()) >= 2));
    check({tag, ".valid_a"}, PKT_W'(iq.ex_valid_a), PKT_W'(mVA));
    check({tag, ".valid_b"}, PKT_W'(iq.ex_valid_b), PKT_W'(mVB));
    if (mVA) check({tag, ".pkt_a"}, iq.ex_pkt_a, mPA);
    if (mVB) check({tag, ".pkt_b"}, iq.ex_pkt_b, mPB);
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] v, input logic [PKT_W-1:0] pa,
                               input logic [PKT_W-1:0] pb, input info_t ia, input info_t ib,
                               input bit fl, input bit st);
    iq.in_valid = v; iq.in_pkt_a = pa; iq.in_pkt_b = pb;
    iq.in_info_a = ia; iq.in_info_b = ib; iq.flush = fl; iq.stall = st;
    modelStep(v, pa, pb, ia, ib, fl, st);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] rv;
    iq.in_valid = '0; iq.in_pkt_a = '0; iq.in_pkt_b = '0;
    iq.in_info_a = '0; iq.in_info_b = '0; iq.flush = 0; iq.stall = 0;
    mVA = 0; mVB = 0; mPA = '0; mPB = '0; mExB = '0;

    #1 rstn = 1'b0;
    #1;
    check("rst.count", PKT_W'(iq.count), '0);
    check("rst.valid_a", PKT_W'(iq.ex_valid_a), '0);
    check("rst.valid_b", PKT_W'(iq.ex_valid_b), '0);
    check("rst.pkt_a", iq.ex_pkt_a, '0);
    check("rst.pkt_b", iq.ex_pkt_b, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst.in_ready", PKT_W'(iq.in_ready), PKT_W'(1));

    // Independent pair issues together.
    applyStimulus("indep.enq", 2'b11, 128'h11, 128'h12, mk(0,0,1,1,2,3), mk(0,0,1,4,5,6), 0, 0);
    idle("indep.issue");
    check("indep.vb", PKT_W'(iq.ex_valid_b), PKT_W'(1));
    check("indep.cnt", PKT_W'(iq.count), '0);

    // RAW on r5 splits the pair.
    applyStimulus("raw.enq", 2'b11, 128'h21, 128'h22, mk(0,0,1,5,1,2), mk(0,0,1,6,5,3), 0, 0);
    idle("raw.c1");
    check("raw.c1.vb", PKT_W'(iq.ex_valid_b), '0);
    check("raw.c1.pa", iq.ex_pkt_a, 128'h21);
    idle("raw.c2");
    check("raw.c2.pa", iq.ex_pkt_a, 128'h22);

    // Load alone in lane B, then a load-use bubble.
    applyStimulus("ld.enq", 2'b11, 128'h31, 128'h32, mk(1,1,1,7,2,0), mk(0,0,1,8,7,1), 0, 0);
    idle("ld.issue");
    check("ld.va", PKT_W'(iq.ex_valid_a), '0);
    check("ld.pb", iq.ex_pkt_b, 128'h31);
    idle("ld.bubble");
    check("ld.bubble.va", PKT_W'(iq.ex_valid_a), '0);
    check("ld.bubble.vb", PKT_W'(iq.ex_valid_b), '0);
    idle("ld.use");
    check("ld.use.pa", iq.ex_pkt_a, 128'h32);

    // Fill under stall, then drain.
    for (int i = 0; i < 5; i++)
      applyStimulus("fill", 2'b11, rndPkt(), rndPkt(), mk(0,0,0,0,i,i), mk(0,0,0,0,i,i), 0, 1);
    check("fill.count", PKT_W'(iq.count), PKT_W'(8));
    check("fill.ready", PKT_W'(iq.in_ready), '0);
    for (int i = 0; i < 5; i++) idle("drain");
    check("drain.count", PKT_W'(iq.count), '0);

    // Flush overrides stall and drops the same-cycle enqueue.
    applyStimulus("fl.pre", 2'b11, rndPkt(), rndPkt(), mk(0,0,1,1,2,3), mk(0,0,1,2,3,4), 0, 1);
    applyStimulus("fl.pre", 2'b11, rndPkt(), rndPkt(), mk(0,0,1,3,2,3), mk(0,0,1,4,3,4), 0, 1);
    applyStimulus("fl.pre", 2'b01, rndPkt(), rndPkt(), mk(0,0,1,5,2,3), '0, 0, 1);
    check("fl.pre.count", PKT_W'(iq.count), PKT_W'(5));
    applyStimulus("fl", 2'b11, rndPkt(), rndPkt(), mk(0,0,1,6,2,3), mk(0,0,1,7,3,4), 1, 1);
    check("fl.count", PKT_W'(iq.count), '0);
    check("fl.va", PKT_W'(iq.ex_valid_a), '0);
    check("fl.vb", PKT_W'(iq.ex_valid_b), '0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++)
      applyStimulus("ar.pre", 2'b11, rndPkt(), rndPkt(), mk(0,0,1,1,2,3), mk(0,0,1,2,3,4), 0, 1);
    check("ar.pre.count", PKT_W'(iq.count), PKT_W'(6));
    iq.in_valid = '0; iq.stall = 0;
    rstn = 1'b0;
    #2;
    check("ar.count", PKT_W'(iq.count), '0);
    check("ar.va", PKT_W'(iq.ex_valid_a), '0);
    check("ar.vb", PKT_W'(iq.ex_valid_b), '0);
    mq.delete(); mVA = 0; mVB = 0; mExB = '0;
    #2 rstn = 1'b1;
    idle("ar.post");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0: rv = 2'b00;
        1: rv = 2'b01;
        default: rv = 2'b11;
      endcase
      applyStimulus("rnd", rv, rndPkt(), rndPkt(), rndInfo(), rndInfo(),
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25);
    end
    for (int i = 0; i < 10; i++) idle("rnd.drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
